// File: rtl/disp_src_sel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | disp_src_sel : registered display-source selector with blanking on every  |
// | mode change. Optional output freeze via `MODE_SEL_HOLD_EN.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module disp_src_sel #(
  parameter int WIDTH        = 14,
  parameter int NUM_CH       = 3,
  parameter int BLANK_CYCLES = 4,
  localparam int MODE_W      = $clog2(NUM_CH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_CH*WIDTH-1:0] i_data,
  input  logic                    i_mode_btn,
  input  logic                    i_mode_load,
  input  logic [MODE_W-1:0]       i_mode_val,
  input  logic                    i_hold,
  output logic [MODE_W-1:0]       o_mode,
  output logic [WIDTH-1:0]        o_muxOut,
  output logic                    o_blank,
  output logic                    o_mode_chg
);

  localparam int                CNT_W     = $clog2(BLANK_CYCLES + 1);
  localparam logic [MODE_W:0]   NUM_CH_V  = (MODE_W + 1)'(NUM_CH);
  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(1);

  typedef enum logic [0:0] {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   sel;
  logic               chg;
  logic [MODE_W-1:0]  next_mode;

`ifndef MODE_SEL_HOLD_EN
  logic unused_hold;
  assign unused_hold = i_hold;
`endif

  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (o_mode == MODE_W'(k)) sel = i_data[k*WIDTH +: WIDTH];
    end
  end

  // A load always swallows a concurrent button press, even if the load is rejected.
  always_comb begin
    chg       = 1'b0;
    next_mode = o_mode;
    if (i_mode_load) begin
      chg       = ({1'b0, i_mode_val} < NUM_CH_V) && (i_mode_val != o_mode);
      next_mode = i_mode_val;
    end else if (i_mode_btn) begin
      chg       = 1'b1;
      next_mode = (o_mode == LAST_MODE) ? '0 : o_mode + MODE_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= SHOW;
      cnt        <= '0;
      o_mode     <= '0;
      o_muxOut   <= '0;
      o_blank    <= 1'b0;
      o_mode_chg <= 1'b0;
    end else begin
      o_mode_chg <= chg;
      if (chg) begin
        o_mode   <= next_mode;
        state    <= BLANK;
        cnt      <= CNT_LOAD;
        o_blank  <= 1'b1;
        o_muxOut <= '0;
      end else begin
        case (state)
          SHOW: begin
`ifdef MODE_SEL_HOLD_EN
            if (!i_hold) o_muxOut <= sel;
`else
            o_muxOut <= sel;
`endif
          end
          BLANK: begin
            // Exit edge always loads the new channel, regardless of hold.
            if (cnt == CNT_LAST) begin
              state    <= SHOW;
              cnt      <= '0;
              o_blank  <= 1'b0;
              o_muxOut <= sel;
            end else begin
              cnt <= cnt - CNT_LAST;
            end
          end
          default: begin
            state   <= SHOW;
            o_blank <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_disp_src_sel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_disp_src_sel : directed self-checking bench for disp_src_sel.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_disp_src_sel;

  localparam int WIDTH  = 14;
  localparam int NUM_CH = 3;
  localparam int MODE_W = 2;

  logic                    clk;
  logic                    rst_n;
  logic [WIDTH-1:0]        ch [NUM_CH];
  logic [NUM_CH*WIDTH-1:0] data;
  logic                    mode_btn;
  logic                    mode_load;
  logic [MODE_W-1:0]       mode_val;
  logic                    hold;
  logic [MODE_W-1:0]       mode;
  logic [WIDTH-1:0]        mux_out;
  logic                    blank;
  logic                    mode_chg;

  int n_cmp;
  int n_err;

  assign data = {ch[2], ch[1], ch[0]};

  disp_src_sel #(
    .WIDTH        (WIDTH),
    .NUM_CH       (NUM_CH),
    .BLANK_CYCLES (4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_data      (data),
    .i_mode_btn  (mode_btn),
    .i_mode_load (mode_load),
    .i_mode_val  (mode_val),
    .i_hold      (hold),
    .o_mode      (mode),
    .o_muxOut    (mux_out),
    .o_blank     (blank),
    .o_mode_chg  (mode_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One pulse, then 4 blanked cycles, then the new channel value.
  task automatic press_and_check(input logic [MODE_W-1:0] exp_mode, input logic [WIDTH-1:0] exp_val);
    mode_btn = 1'b1;
    step();
    mode_btn = 1'b0;
    chk("btn_mode", 32'(mode), 32'(exp_mode));
    chk("btn_chg", 32'(mode_chg), 32'd1);
    chk("btn_blank0", 32'(blank), 32'd1);
    chk("btn_mux0", 32'(mux_out), 32'd0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("blank_hold", 32'(blank), 32'd1);
      chk("blank_mux", 32'(mux_out), 32'd0);
      chk("chg_once", 32'(mode_chg), 32'd0);
    end
    step();
    chk("unblank", 32'(blank), 32'd0);
    chk("new_val", 32'(mux_out), 32'(exp_val));
    for (int i = 0; i < 5; i++) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    int nc;
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    mode_btn  = 1'b0;
    mode_load = 1'b0;
    mode_val  = '0;
    hold      = 1'b0;
    ch[0]     = 14'h0123;
    ch[1]     = 14'h0456;
    ch[2]     = 14'h3FFF;

    step();
    step();
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_mux", 32'(mux_out), 32'd0);
    chk("rst_blank", 32'(blank), 32'd0);
    chk("rst_chg", 32'(mode_chg), 32'd0);

    rst_n = 1'b1;
    step();
    chk("show_ch0", 32'(mux_out), 32'h0123);
    chk("show_mode0", 32'(mode), 32'd0);
    chk("show_blank", 32'(blank), 32'd0);
    for (int i = 0; i < 5; i++) step();

    press_and_check(2'd1, 14'h0456);
    press_and_check(2'd2, 14'h3FFF);
    press_and_check(2'd0, 14'h0123);

    // Out-of-range load is ignored.
    mode_load = 1'b1;
    mode_val  = 2'd3;
    step();
    mode_load = 1'b0;
    chk("oor_mode", 32'(mode), 32'd0);
    chk("oor_chg", 32'(mode_chg), 32'd0);
    chk("oor_blank", 32'(blank), 32'd0);
    step();
    chk("oor_mux", 32'(mux_out), 32'h0123);

    // Load beats button.
    mode_load = 1'b1;
    mode_val  = 2'd2;
    mode_btn  = 1'b1;
    step();
    mode_load = 1'b0;
    mode_btn  = 1'b0;
    chk("prio_mode", 32'(mode), 32'd2);
    chk("prio_chg", 32'(mode_chg), 32'd1);
    step();
    chk("prio_chg_once", 32'(mode_chg), 32'd0);
    chk("prio_mode_stay", 32'(mode), 32'd2);
    step();
    step();
    step();
    chk("prio_show", 32'(mux_out), 32'h3FFF);
    chk("prio_unblank", 32'(blank), 32'd0);
    for (int i = 0; i < 3; i++) step();

    // Second press two cycles into blanking restarts it: 2+4 blank cycles.
    nb = 0;
    nc = 0;
    mode_btn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      mode_btn = (i == 1);
      if (blank) nb++;
      if (mode_chg) nc++;
    end
    chk("restart_blanks", 32'(nb), 32'd6);
    chk("restart_strobes", 32'(nc), 32'd2);
    chk("restart_mode", 32'(mode), 32'd1);
    chk("restart_val", 32'(mux_out), 32'h0456);

    // Hold while channel 1 changes.
    hold  = 1'b1;
    ch[1] = 14'h0789;
    step();
`ifdef MODE_SEL_HOLD_EN
    chk("hold_frozen", 32'(mux_out), 32'h0456);
`else
    chk("hold_ignored", 32'(mux_out), 32'h0789);
`endif
    step();
`ifdef MODE_SEL_HOLD_EN
    chk("hold_frozen2", 32'(mux_out), 32'h0456);
`else
    chk("hold_ignored2", 32'(mux_out), 32'h0789);
`endif

    // Mode change while held: still blanks, then shows the new channel once.
    press_and_check(2'd2, 14'h3FFF);
    ch[2] = 14'h1111;
    step();
`ifdef MODE_SEL_HOLD_EN
    chk("hold_after_blank", 32'(mux_out), 32'h3FFF);
`else
    chk("track_after_blank", 32'(mux_out), 32'h1111);
`endif
    hold = 1'b0;
    step();
    chk("hold_release", 32'(mux_out), 32'h1111);

    // Asynchronous reset in the middle of blanking.
    mode_btn = 1'b1;
    step();
    mode_btn = 1'b0;
    chk("pre_rst_blank", 32'(blank), 32'd1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mode", 32'(mode), 32'd0);
    chk("arst_blank", 32'(blank), 32'd0);
    chk("arst_mux", 32'(mux_out), 32'd0);
    chk("arst_chg", 32'(mode_chg), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ch0", 32'(mux_out), 32'h0123);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/disp_src_sel.md
# disp_src_sel

Registered, parametrised display-source selector feeding the FND/display driver. It picks one of NUM_CH equal-width value channels (timer, up-counter, PWM duty, …) under a mode register that steps on a button pulse or loads directly. Every mode change blanks the output for a fixed number of cycles so the display never shows a torn or mixed value. It replaces the free-running combinational mode mux in front of the display decoder.

## Interface
- WIDTH, 14, bit width of each channel and of the output
- NUM_CH, 3, number of input channels; must be ≥ 2
- BLANK_CYCLES, 4, blanking length after a mode change; must be ≥ 1
- MODE_W (localparam), $clog2(NUM_CH), width of the mode value
- i_clk  in  1  system clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_data  in  NUM_CH*WIDTH  packed channels; channel k is i_data[k*WIDTH +: WIDTH]
- i_mode_btn  in  1  single-cycle, already-debounced pulse; advances the mode by 1
- i_mode_load  in  1  direct mode load strobe
- i_mode_val  in  MODE_W  mode value applied with i_mode_load
- i_hold  in  1  freeze displayed value (active only with MODE_SEL_HOLD_EN)
- o_mode  out  MODE_W  current mode
- o_muxOut  out  WIDTH  registered selected value
- o_blank  out  1  high while output is blanked
- o_mode_chg  out  1  one-cycle strobe on an accepted mode change

## Operation
- Reset (async assert, sync release to the clock): o_mode=0, o_muxOut=0, o_blank=0, o_mode_chg=0, state SHOW, blank counter=0.
- States:
  - SHOW: o_muxOut <= channel[o_mode] every cycle.
  - BLANK: o_muxOut <= 0; o_blank=1; counter counts down from BLANK_CYCLES.
- Mode request resolution, each cycle:
  - i_mode_load high: if i_mode_val < NUM_CH and ≠ o_mode, it is accepted as the new mode.
    - An out-of-range value is ignored entirely.
    - A load equal to o_mode is no change: no strobe, no blank.
  - Else i_mode_btn high: new mode = o_mode+1, wrapping NUM_CH-1 → 0.
  - i_mode_load has priority over i_mode_btn. If both are asserted, the button is dropped, even when the load itself is rejected.
- Accepted change (from either state):
  - o_mode updated.
  - o_mode_chg pulses.
  - State goes to BLANK and the counter reloads to BLANK_CYCLES.
  - A change during BLANK therefore restarts blanking.
- BLANK → SHOW when the counter reaches its final cycle. The first SHOW cycle always loads the new channel.
- Channel data is sampled without synchronisation; inputs are in the i_clk domain.

## Timing
- Latency: channel input → o_muxOut is 1 cycle in SHOW.
- Button sampled at edge t:
  - Edge t+1: o_mode=new, o_mode_chg=1 for this cycle only, o_blank=1, o_muxOut=0.
  - o_blank stays high for exactly BLANK_CYCLES cycles, edges t+1 … t+BLANK_CYCLES.
  - Edge t+BLANK_CYCLES+1: o_blank=0 and o_muxOut = channel[new] as sampled at edge t+BLANK_CYCLES+1.
- Back-to-back button pulses: each one is accepted, giving one strobe per pulse and one increment per pulse.
- Reset asserted mid-BLANK: all outputs return to reset values immediately (asynchronously).

## Configuration
- MODE_SEL_HOLD_EN defined:
  - i_hold high in SHOW keeps o_muxOut at its last value.
  - i_hold has no effect on o_mode, mode changes, or BLANK.
  - The first SHOW cycle after BLANK always loads the new channel; the hold applies from the following cycle.
- Not defined: i_hold is ignored (port kept, unconnected internally). SHOW always tracks the channel.

## Test plan
- Reset, then data ch0=0x0123, ch1=0x0456, ch2=0x3FFF with no requests → o_mode=0, o_muxOut=0x0123 one cycle after release, o_blank=0.
- Three button pulses spaced 10 cycles apart → o_mode sequence 1, 2, 0. Each pulse gives exactly 4 o_blank cycles with o_muxOut=0, one o_mode_chg pulse, then 0x0456, 0x3FFF, 0x0123.
- i_mode_load with i_mode_val=3 (NUM_CH=3) → no change, no strobe. i_mode_val=2 with i_mode_btn in the same cycle → o_mode=2 (not 1), single strobe.
- Button pulse, then a second pulse 2 cycles into BLANK → o_mode advances twice. Blank lasts 2+4 cycles total; two strobes.
- With MODE_SEL_HOLD_EN: i_hold=1 while ch1 changes from 0x0456 to 0x0789 → o_muxOut stays 0x0456. Button press while held → blank 4 cycles, then new channel value shown once and frozen. Without the macro → 0x0789 appears 1 cycle after the change.
- Assert i_rst_n=0 during BLANK → o_mode=0, o_blank=0, o_muxOut=0 with no clock edge needed.
